// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core types: writeback select, load funct3 codes, datapath width
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM->WB pipeline inputs, load data and register-file/forwarding outputs
interface wb_stage_if #(
  parameter int XLEN = cpu_pkg::XLEN
);
  import cpu_pkg::*;

  logic            in_valid;
  logic            in_reg_write;
  wb_sel_e         in_wb_sel;
  logic [2:0]      in_funct3;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_pc4;
  logic [XLEN-1:0] dmem_rdata;

  logic            rf_write_en;
  logic [4:0]      rf_write_reg;
  logic [XLEN-1:0] rf_write_data;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;

  // MEM stage / data SRAM side: produces the instruction and load data
  modport master (
    output in_valid, in_reg_write, in_wb_sel, in_funct3, in_rd,
           in_alu_result, in_pc4, dmem_rdata,
    input  rf_write_en, rf_write_reg, rf_write_data,
           fwd_valid, fwd_rd, fwd_data
  );

  // Writeback stage side
  modport slave (
    input  in_valid, in_reg_write, in_wb_sel, in_funct3, in_rd,
           in_alu_result, in_pc4, dmem_rdata,
    output rf_write_en, rf_write_reg, rf_write_data,
           fwd_valid, fwd_rd, fwd_data
  );
endinterface

// File: rtl/wb_stage_load_extract.sv
// rtl/wb_stage_load_extract.sv - byte/halfword/word selection and extension of load data
module load_extract
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/halfword, then extend by load type; reserved codes read as zero
  always_comb begin
    byte_sel = data[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? data[16 +: 16] : data[0 +: 16];
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   result = data;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB register, writeback mux, RF write port, forwarding, instret; optional WB_BYPASS_EN
module wb_stage
  import cpu_pkg::*;
#(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  wb_stage_if.slave        wb,
  output logic [CNT_W-1:0] instret
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [XLEN-1:0]  rf_rdata1,
  input  logic [XLEN-1:0]  rf_rdata2,
  output logic [XLEN-1:0]  id_rdata1,
  output logic [XLEN-1:0]  id_rdata2
`endif
);

  logic            valid_q;
  logic            reg_write_q;
  wb_sel_e         wb_sel_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] alu_result_q;
  logic [XLEN-1:0] pc4_q;
  logic [CNT_W-1:0] instret_q;

  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wb_data;
  logic            write_en;

  // MEM/WB register: reset clears everything, flush inserts a bubble, stall holds
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      wb_sel_q     <= WB_ALU;
      funct3_q     <= '0;
      rd_q         <= '0;
      alu_result_q <= '0;
      pc4_q        <= '0;
    end else if (flush) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
    end else if (!stall) begin
      valid_q      <= wb.in_valid;
      reg_write_q  <= wb.in_reg_write;
      wb_sel_q     <= wb.in_wb_sel;
      funct3_q     <= wb.in_funct3;
      rd_q         <= wb.in_rd;
      alu_result_q <= wb.in_alu_result;
      pc4_q        <= wb.in_pc4;
    end
  end

  // Retire count: an instruction counts on the edge it leaves WB, so a stalled one counts once
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (valid_q && !stall) begin
      instret_q <= instret_q + 1'b1;
    end
  end

  load_extract #(.XLEN(XLEN)) u_load_extract (
    .data   (wb.dmem_rdata),
    .funct3 (funct3_q),
    .offset (alu_result_q[1:0]),
    .result (load_data)
  );

  // Writeback value select; the unused encoding falls back to the ALU result
  always_comb begin
    case (wb_sel_q)
      WB_MEM:  wb_data = load_data;
      WB_PC4:  wb_data = pc4_q;
      default: wb_data = alu_result_q;
    endcase
  end

  // x0 writes are dropped here so the register file need not special-case them
  assign write_en         = valid_q & reg_write_q & (rd_q != 5'd0);

  assign wb.rf_write_en   = write_en;
  assign wb.rf_write_reg  = rd_q;
  assign wb.rf_write_data = wb_data;
  assign wb.fwd_valid     = write_en;
  assign wb.fwd_rd        = rd_q;
  assign wb.fwd_data      = wb_data;
  assign instret          = instret_q;

`ifdef WB_BYPASS_EN
  // Write-before-read for decode: a same-cycle WB write overrides the stale RF read
  always_comb begin
    id_rdata1 = (write_en && (rs1 == rd_q)) ? wb_data : rf_rdata1;
    id_rdata2 = (write_en && (rs2 == rd_q)) ? wb_data : rf_rdata2;
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage with a behavioural retire/writeback model
module tb_wb_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [63:0] instret;

  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(32)) wb ();

`ifdef WB_BYPASS_EN
  logic [4:0]  rs1, rs2;
  logic [31:0] rf_rdata1, rf_rdata2, id_rdata1, id_rdata2;
`endif

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .flush   (flush),
    .wb      (wb),
    .instret (instret)
`ifdef WB_BYPASS_EN
    ,
    .rs1       (rs1),
    .rs2       (rs2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .id_rdata1 (id_rdata1),
    .id_rdata2 (id_rdata2)
`endif
  );

  // reference state: the instruction currently sitting in writeback, and the retire total
  logic        m_valid, m_rw;
  logic [1:0]  m_sel;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_pc4, cur_dmem;
  logic [63:0] m_cnt;
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] ref_load(logic [31:0] d, logic [2:0] f3, logic [1:0] a);
    int unsigned b, h;
    b = (d >> (8 * a)) & 32'hFF;
    h = (d >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      3'd2:    return d;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_data();
    if (m_sel == 2'd1) return ref_load(cur_dmem, m_f3, m_alu[1:0]);
    if (m_sel == 2'd2) return m_pc4;
    return m_alu;
  endfunction

  function automatic logic exp_en();
    return m_valid && m_rw && (m_rd != 5'd0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc4);
    wb.in_valid      = v;
    wb.in_reg_write  = rw;
    wb.in_wb_sel     = wb_sel_e'(sel);
    wb.in_funct3     = f3;
    wb.in_rd         = rd;
    wb.in_alu_result = alu;
    wb.in_pc4        = pc4;
  endtask

  task automatic model_update();
    if (rst) begin
      m_valid = 0; m_rw = 0; m_sel = 0; m_f3 = 0; m_rd = 0; m_alu = 0; m_pc4 = 0; m_cnt = 0;
    end else begin
      if (m_valid && !stall) m_cnt = m_cnt + 64'd1;
      if (flush) begin
        m_valid = 0; m_rw = 0;
      end else if (!stall) begin
        m_valid = wb.in_valid;      m_rw  = wb.in_reg_write;
        m_sel   = wb.in_wb_sel;     m_f3  = wb.in_funct3;
        m_rd    = wb.in_rd;         m_alu = wb.in_alu_result;
        m_pc4   = wb.in_pc4;
      end
    end
  endtask

  task automatic check_all();
    chk("rf_write_en",   {63'd0, wb.rf_write_en}, {63'd0, exp_en()});
    chk("rf_write_reg",  {59'd0, wb.rf_write_reg}, {59'd0, m_rd});
    chk("rf_write_data", {32'd0, wb.rf_write_data}, {32'd0, exp_data()});
    chk("fwd_valid",     {63'd0, wb.fwd_valid}, {63'd0, exp_en()});
    chk("fwd_rd",        {59'd0, wb.fwd_rd}, {59'd0, m_rd});
    chk("fwd_data",      {32'd0, wb.fwd_data}, {32'd0, exp_data()});
    chk("instret",       instret, m_cnt);
`ifdef WB_BYPASS_EN
    chk("id_rdata1", {32'd0, id_rdata1},
        {32'd0, (exp_en() && rs1 == m_rd) ? exp_data() : rf_rdata1});
    chk("id_rdata2", {32'd0, id_rdata2},
        {32'd0, (exp_en() && rs2 == m_rd) ? exp_data() : rf_rdata2});
`endif
  endtask

  // one clock: model follows the edge, then the WB-cycle load data is applied and outputs compared
  task automatic step(input logic [31:0] dm);
    @(posedge clk);
    #1;
    model_update();
    cur_dmem = dm;
    wb.dmem_rdata = dm;
    #1;
    check_all();
  endtask

  initial begin
    logic [63:0] c0;
    logic [2:0]  f3_tab [8];
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    rst = 1; stall = 0; flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    wb.dmem_rdata = 0; cur_dmem = 0;
`ifdef WB_BYPASS_EN
    rs1 = 0; rs2 = 0; rf_rdata1 = 0; rf_rdata2 = 0;
`endif
    step(0);
    step(0);
    chk("reset_rf_write_en", {63'd0, wb.rf_write_en}, 64'd0);
    chk("reset_rf_write_data", {32'd0, wb.rf_write_data}, 64'd0);
    chk("reset_instret", instret, 64'd0);

    // ALU op rd=5
    rst = 0;
    drive(1, 1, 0, 0, 5'd5, 32'h1234_5678, 32'h0);
    step(0);
    chk("alu_data", {32'd0, wb.rf_write_data}, 64'h1234_5678);
    chk("alu_en", {63'd0, wb.rf_write_en}, 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step(0);
    chk("alu_instret", instret, 64'd1);

    // loads
    drive(1, 1, 1, F3_LB, 5'd3, 32'h1000_0003, 0);
    step(32'h80FF_0000);
    chk("lb_data", {32'd0, wb.rf_write_data}, 64'hFFFF_FF80);
    drive(1, 1, 1, F3_LBU, 5'd3, 32'h1000_0003, 0);
    step(32'h80FF_0000);
    chk("lbu_data", {32'd0, wb.rf_write_data}, 64'h0000_0080);
    drive(1, 1, 1, F3_LHU, 5'd3, 32'h1000_0002, 0);
    step(32'h80FF_0000);
    chk("lhu_data", {32'd0, wb.rf_write_data}, 64'h0000_80FF);

    // x0 write suppressed but still retires
    drive(1, 1, 0, 0, 5'd0, 32'hAAAA_5555, 0);
    step(0);
    chk("x0_en", {63'd0, wb.rf_write_en}, 64'd0);

    // stall for 3 cycles
    drive(1, 1, 0, 0, 5'd9, 32'h0BAD_F00D, 0);
    step(0);
    c0 = m_cnt;
    stall = 1;
    drive(1, 1, 2, 0, 5'd4, 32'h1111_2222, 32'h3333_4444);
    for (int i = 0; i < 3; i++) begin
      step(0);
      chk("stall_data", {32'd0, wb.rf_write_data}, 64'h0BAD_F00D);
      chk("stall_reg", {59'd0, wb.rf_write_reg}, 64'd9);
    end
    stall = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step(0);
    chk("stall_instret", instret, c0 + 64'd1);

    // flush together with stall
    drive(1, 1, 0, 0, 5'd6, 32'h6666_6666, 0);
    step(0);
    stall = 1; flush = 1;
    step(0);
    chk("flush_stall_en", {63'd0, wb.rf_write_en}, 64'd0);
    stall = 0; flush = 0;

    // JAL rd=1
    drive(1, 1, 2, 0, 5'd1, 32'h0000_0200, 32'h0000_0104);
    step(0);
    chk("jal_data", {32'd0, wb.rf_write_data}, 64'h0000_0104);

    // counter wrap: retire two instructions from 2^64-1
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(1, 1, 0, 0, 5'd2, 32'h2, 0);
    step(0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step(0);
    chk("wrap_instret", instret, 64'd1);

    // reset while stalled
    drive(1, 1, 0, 0, 5'd8, 32'h8888_0000, 0);
    step(0);
    stall = 1;
    step(0);
    rst = 1;
    step(0);
    chk("rst_stall_instret", instret, 64'd0);
    chk("rst_stall_en", {63'd0, wb.rf_write_en}, 64'd0);
    rst = 0; stall = 0;

`ifdef WB_BYPASS_EN
    drive(1, 1, 0, 0, 5'd7, 32'hDEAD_BEEF, 0);
    rs1 = 7; rf_rdata1 = 0; rs2 = 8; rf_rdata2 = 32'h1357_9BDF;
    step(0);
    chk("byp_rdata1", {32'd0, id_rdata1}, 64'hDEAD_BEEF);
    chk("byp_rdata2", {32'd0, id_rdata2}, 64'h1357_9BDF);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 99) < 2);
      stall = ($urandom_range(0, 99) < 25);
      flush = ($urandom_range(0, 99) < 10);
      drive($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 2)),
            f3_tab[$urandom_range(0, 7)], 5'($urandom_range(0, 31)), $urandom, $urandom);
`ifdef WB_BYPASS_EN
      rs1 = ($urandom_range(0, 1) != 0) ? wb.in_rd : 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      rf_rdata1 = $urandom; rf_rdata2 = $urandom;
`endif
      step($urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 5-stage RV32I core: holds the MEM/WB pipeline register, aligns and sign-extends load data arriving one cycle late from the synchronous data SRAM, selects the writeback value and drives the write port of the integer register file. It also supplies the EX-stage forwarding source and the retired-instruction count (minstret source).

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 64, width of the retired-instruction counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold MEM/WB register (hazard unit)
- flush  in  1  insert bubble into MEM/WB register
- in_valid  in  1  MEM stage holds a real instruction
- in_reg_write  in  1  instruction writes rd
- in_wb_sel  in  2  wb_sel_e: ALU / MEM / PC4
- in_funct3  in  3  load type
- in_rd  in  5  destination register
- in_alu_result  in  XLEN  ALU result; also load address
- in_pc4  in  XLEN  PC+4 for JAL/JALR
- dmem_rdata  in  XLEN  SRAM read data, valid in the WB cycle of a load
- rf_write_en  out  1  register-file write enable
- rf_write_reg  out  5  register-file write address
- rf_write_data  out  XLEN  register-file write data
- fwd_valid  out  1  forwarding source valid (equals rf_write_en)
- fwd_rd  out  5  forwarding destination
- fwd_data  out  XLEN  forwarding value (equals rf_write_data)
- instret  out  CNT_W  retired-instruction count

## Operation
- MEM/WB register fields: valid, reg_write, wb_sel, funct3, rd, alu_result, pc4.
- Update priority at posedge: rst > flush > stall > load.
  - rst or flush: valid=0; reg_write=0.
  - Other fields don't-care.
- stall: all fields hold.
- Otherwise all fields load from in_*.
- Writeback value:
  - ALU: alu_result.
  - PC4: pc4.
  - MEM: load_extract(dmem_rdata, funct3, alu_result[1:0]).
- Load extract:
  - LB/LBU select byte alu_result[1:0].
  - LH/LHU select halfword alu_result[1]; alu_result[0] ignored.
  - LW ignores offset.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Reserved funct3 (3, 6, 7) yields 0.
- rf_write_en = valid & reg_write & (rd != 0). Writes to x0 are suppressed here, not in the register file.
- rf_write_reg = rd; rf_write_data = writeback value, both regardless of enable.
- instret increments by 1 in every cycle with valid & !stall & !rst, wraps at 2^CNT_W. A stalled instruction counts once, on the cycle it leaves.

## Timing
- Reset values:
  - rf_write_en=0, fwd_valid=0, instret=0.
  - rf_write_reg/fwd_rd=0, rf_write_data/fwd_data=0: fields reset to 0 as well.
- Latency: an instruction accepted at edge N drives rf_write_* during cycle N+1. The register file captures it at edge N+2.
- The dmem read is issued in MEM at cycle N; dmem_rdata is combinational input in cycle N+1.
- During stall, rf_write_* stays asserted with identical values; the repeated write is idempotent.
- flush and stall together: flush wins and valid clears.
- rst mid-stall clears the register and does not increment instret.
- Outputs are combinational from the pipeline register and dmem_rdata only; no path from in_* to outputs.

## Configuration
- WB_BYPASS_EN defined:
  - Adds ports rs1, rs2 (in, 5), rf_rdata1, rf_rdata2 (in, XLEN), id_rdata1, id_rdata2 (out, XLEN).
  - id_rdataK = rf_write_data when rf_write_en & (rsK == rf_write_reg), else rf_rdataK.
  - This gives write-before-read semantics to decode in the same cycle.
- WB_BYPASS_EN undefined: ports absent. The hazard unit stalls decode one cycle on a WB→ID RAW match.

## Structure
- Shared package cpu_pkg holds:
  - wb_sel_e (WB_ALU=2'd0, WB_MEM=2'd1, WB_PC4=2'd2).
  - Load funct3 constants F3_LB=0, F3_LH=1, F3_LW=2, F3_LBU=4, F3_LHU=5.
  - XLEN default.
- One sub-module, load_extract: pure combinational data, funct3, offset → XLEN result.

## Test plan
- Reset, then ALU op rd=5, alu_result=0x1234_5678 → one cycle later rf_write_en=1, rf_write_reg=5, rf_write_data=0x1234_5678; instret=1 after the next edge.
- LB rd=3, alu_result[1:0]=3, dmem_rdata=0x80FF_0000 → rf_write_data=0xFFFF_FF80. LBU same → 0x0000_0080. LHU offset 2 → 0x0000_80FF.
- Write to rd=0 with reg_write=1 → rf_write_en=0, instret still increments.
- stall held 3 cycles on a valid ALU op → rf_write_* constant for 4 cycles, instret +1 total. Flush with stall → bubble, rf_write_en=0.
- JAL rd=1, pc4=0x0000_0104 → rf_write_data=0x0000_0104. Set instret near 2^64−1 via force, retire 2 → wraps to 1.
- WB_BYPASS_EN: WB writes x7=0xDEAD_BEEF, rs1=7, rf_rdata1=0 → id_rdata1=0xDEAD_BEEF. rs2=8 → id_rdata2=rf_rdata2.
